shift_mix_round: RTL

Round-completion stage placed directly downstream of the 16-lane SBox unit in the Versat AES datapath. It consumes the 16 substituted state bytes and applies ShiftRows, then MixColumns (one column per cycle), then AddRoundKey with a memory-mapped round key. It presents the new 16-byte state on registered outputs for the next round's SBox. A config bit selects final-round mode, which bypasses MixColumns.

---
 rtl/aes_pkg.sv | 18 +
 rtl/shift_mix_round_mix_column.sv | 29 ++
 rtl/shift_mix_round.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, types and byte helpers for the AES round datapath
`timescale 1ns/1ps
package aes_pkg;
    localparam logic [2:0] ADDR_KEY0 = 3'd0;
    localparam logic [2:0] ADDR_KEY1 = 3'd1;
    localparam logic [2:0] ADDR_KEY2 = 3'd2;
    localparam logic [2:0] ADDR_KEY3 = 3'd3;
    localparam logic [2:0] ADDR_CTRL = 3'd4;

    // Indexed [column][row] so one column slices out as a 32-bit word.
    typedef logic [3:0][3:0][7:0] byte_mat_t;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/shift_mix_round_mix_column.sv
// rtl/shift_mix_round_mix_column.sv - combinational MixColumns on one column, with final-round bypass
`timescale 1ns/1ps
module mix_column
    import aes_pkg::*;
(
    input  logic [3:0][7:0] a_i,
    input  logic            bypass_i,
    output logic [3:0][7:0] y_o
);
    logic [3:0][7:0] x2;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            x2[r] = xtime(a_i[r]);
        end
    end

    // 3*a is expressed as xtime(a) ^ a.
    always_comb begin
        if (bypass_i) begin
            y_o = a_i;
        end else begin
            y_o[0] = x2[0] ^ x2[1] ^ a_i[1] ^ a_i[2] ^ a_i[3];
            y_o[1] = a_i[0] ^ x2[1] ^ x2[2] ^ a_i[2] ^ a_i[3];
            y_o[2] = a_i[0] ^ a_i[1] ^ x2[2] ^ x2[3] ^ a_i[3];
            y_o[3] = x2[0] ^ a_i[0] ^ a_i[1] ^ a_i[2] ^ x2[3];
        end
    end
endmodule

// File: rtl/shift_mix_round.sv
// rtl/shift_mix_round.sv - ShiftRows, column-serial MixColumns and AddRoundKey round stage
`timescale 1ns/1ps
module shift_mix_round
    import aes_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    input  logic [DATA_W-1:0] in5,
    input  logic [DATA_W-1:0] in6,
    input  logic [DATA_W-1:0] in7,
    input  logic [DATA_W-1:0] in8,
    input  logic [DATA_W-1:0] in9,
    input  logic [DATA_W-1:0] in10,
    input  logic [DATA_W-1:0] in11,
    input  logic [DATA_W-1:0] in12,
    input  logic [DATA_W-1:0] in13,
    input  logic [DATA_W-1:0] in14,
    input  logic [DATA_W-1:0] in15,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic [DATA_W-1:0] out6,
    output logic [DATA_W-1:0] out7,
    output logic [DATA_W-1:0] out8,
    output logic [DATA_W-1:0] out9,
    output logic [DATA_W-1:0] out10,
    output logic [DATA_W-1:0] out11,
    output logic [DATA_W-1:0] out12,
    output logic [DATA_W-1:0] out13,
    output logic [DATA_W-1:0] out14,
    output logic [DATA_W-1:0] out15,
    output logic              busy,
    output logic              done,
    input  logic              valid,
    input  logic [2:0]        addr,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata
);
    state_t            state_q, state_d;
    logic [1:0]        col_q;
    byte_mat_t         work_q, out_q, shifted, result;
    logic [3:0][31:0]  key_q, wkey_q;
    logic              last_q, wlast_q, done_q, ready_q;
    logic [DATA_W-1:0] rdata_q, rd_val;
    logic [15:0][DATA_W-1:0] in_w, out_w;
    logic [15:0][7:0]  in_b;
    logic [3:0][7:0]   mix_y;
    logic              unused_in_hi;

    assign in_w = {in15, in14, in13, in12, in11, in10, in9, in8,
                   in7, in6, in5, in4, in3, in2, in1, in0};

    always_comb begin
        unused_in_hi = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_b[i]      = in_w[i][7:0];
            unused_in_hi = unused_in_hi ^ (^in_w[i][DATA_W-1:8]);
        end
    end

    // ShiftRows is pure wiring: row r of column c comes from column (c+r)%4.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[c][r] = in_b[4*((c+r)%4)+r];
            end
        end
    end

    mix_column u_mix (
        .a_i      (work_q[col_q]),
        .bypass_i (wlast_q),
        .y_o      (mix_y)
    );

    always_comb begin
        result         = work_q;
        result[col_q]  = mix_y ^ wkey_q[col_q];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run) state_d = BUSY;
            BUSY:    if (col_q == 2'd3) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == BUSY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q   <= 2'd0;
            work_q  <= '0;
            out_q   <= '0;
            wkey_q  <= '0;
            wlast_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == BUSY) && (col_q == 2'd3);
            if (state_q == IDLE && run) begin
                work_q  <= shifted;
                wkey_q  <= key_q;
                wlast_q <= last_q;
                col_q   <= 2'd0;
            end else if (state_q == BUSY) begin
                work_q <= result;
                col_q  <= col_q + 2'd1;
                if (col_q == 2'd3) out_q <= result;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            ADDR_KEY0, ADDR_KEY1, ADDR_KEY2, ADDR_KEY3: rd_val = DATA_W'(key_q[addr[1:0]]);
            ADDR_CTRL: rd_val = DATA_W'(last_q);
            default:   rd_val = '0;
        endcase
    end

    // Live registers only; an in-flight block keeps its own snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q   <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= valid;
            rdata_q <= valid ? rd_val : '0;
            if (valid && (|wstrb)) begin
                if (addr[2] == 1'b0) begin
                    for (int j = 0; j < 4; j++) begin
                        if (wstrb[j]) key_q[addr[1:0]][8*j +: 8] <= wdata[8*j +: 8];
                    end
                end else if (addr == ADDR_CTRL && wstrb[0]) begin
                    last_q <= wdata[0];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            out_w[i] = DATA_W'(out_q[i/4][i%4]);
        end
    end

    assign {out15, out14, out13, out12, out11, out10, out9, out8,
            out7, out6, out5, out4, out3, out2, out1, out0} = out_w;

    assign done  = done_q;
    assign ready = ready_q;
    assign rdata = rdata_q;
endmodule
